// File: rtl/mpx_hilo.sv
// ---------------------------------------------------------------------------
// mpx_hilo -- HI/LO register file with divide scoreboard for a MIPS-style core.
//
// Decodes DIV/DIVU/MFHI/MFLO/MTHI/MTLO, tracks an outstanding divide,
// stalls MFHI/MFLO while the divide is pending, and captures divider
// writebacks into HI/LO.
//
// Optional feature macro: MPX_HILO_BYPASS_EN
//   When defined, an MFHI/MFLO in the same cycle as the divider writeback
//   is not stalled; the writeback value is forwarded straight to result_o.
// ---------------------------------------------------------------------------
module mpx_hilo (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        opcode_valid_i,
    input  logic [31:0] opcode_opcode_i,
    input  logic [31:0] opcode_rs_operand_i,
    input  logic        div_valid_i,
    input  logic [31:0] div_hi_i,
    input  logic [31:0] div_lo_i,
    output logic        stall_o,
    output logic        busy_o,
    output logic        result_valid_o,
    output logic [31:0] result_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic [5:0] FUNCT_MFHI = 6'h10;
    localparam logic [5:0] FUNCT_MTHI = 6'h11;
    localparam logic [5:0] FUNCT_MFLO = 6'h12;
    localparam logic [5:0] FUNCT_MTLO = 6'h13;
    localparam logic [5:0] FUNCT_DIV  = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU = 6'h1B;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_result_valid;
    logic [31:0] r_result;

    logic        w_special;
    logic [5:0]  w_funct;
    logic        w_is_div;
    logic        w_is_mfhi;
    logic        w_is_mflo;
    logic        w_is_mthi;
    logic        w_is_mtlo;
    logic        w_is_mf;
    logic        w_stall;
    logic        w_busy;
    logic        w_mf_accept;
    logic        w_use_bypass;
    logic [31:0] w_mf_data;
    logic        w_unused_fields;

    // Only the primary opcode and funct fields take part in decode.
    assign w_special       = (opcode_opcode_i[31:26] == 6'h00);
    assign w_funct         = opcode_opcode_i[5:0];
    assign w_unused_fields = ^opcode_opcode_i[25:6];

    assign w_is_div  = opcode_valid_i & w_special &
                       ((w_funct == FUNCT_DIV) | (w_funct == FUNCT_DIVU));
    assign w_is_mfhi = opcode_valid_i & w_special & (w_funct == FUNCT_MFHI);
    assign w_is_mflo = opcode_valid_i & w_special & (w_funct == FUNCT_MFLO);
    assign w_is_mthi = opcode_valid_i & w_special & (w_funct == FUNCT_MTHI);
    assign w_is_mtlo = opcode_valid_i & w_special & (w_funct == FUNCT_MTLO);
    assign w_is_mf   = w_is_mfhi | w_is_mflo;

`ifdef MPX_HILO_BYPASS_EN
    // A writeback landing while BUSY can be forwarded to a waiting MF.
    assign w_use_bypass = (r_state == ST_BUSY) & div_valid_i;
`else
    assign w_use_bypass = 1'b0;
`endif

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, busy and stall decode.
    // NOTE: every output of this block is defaulted first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_stall     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_is_div) begin
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                w_busy  = 1'b1;
                w_stall = w_is_mf & ~w_use_bypass;
                if (w_is_div) begin
                    w_state_nxt = ST_BUSY;   // divider restarts
                end else if (div_valid_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_mf_accept = w_is_mf & ~w_stall;
    assign w_mf_data   = w_use_bypass ? (w_is_mfhi ? div_hi_i : div_lo_i)
                                      : (w_is_mfhi ? r_hi     : r_lo);

    // HI/LO update: divider writeback has priority over MTHI/MTLO.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_hi <= 32'h0;
            r_lo <= 32'h0;
        end else begin
            if (div_valid_i) begin
                r_hi <= div_hi_i;
                r_lo <= div_lo_i;
            end else begin
                if (w_is_mthi) r_hi <= opcode_rs_operand_i;
                if (w_is_mtlo) r_lo <= opcode_rs_operand_i;
            end
        end
    end

    // MF result: one-cycle strobe, data held between strobes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_result_valid <= 1'b0;
            r_result       <= 32'h0;
        end else begin
            r_result_valid <= w_mf_accept;
            if (w_mf_accept) begin
                r_result <= w_mf_data;
            end
        end
    end

    assign stall_o        = w_stall;
    assign busy_o         = w_busy;
    assign result_valid_o = r_result_valid;
    assign result_o       = r_result;
    assign hi_o           = r_hi;
    assign lo_o           = r_lo;

endmodule
